hazard_unit: RTL and testbench

Parametrised pipeline hazard controller for the five-stage MIPS datapath. It keeps a shadow pipeline of in-flight instruction metadata, one entry per post-decode stage. From that state it generates:
- per-latch enable and flush controls;
- load-use and no-forwarding stalls;
- branch/jump redirect flushes;
- operand forwarding selects;
- a sticky halt.

It sits beside the control unit and drives the PC and every pipeline latch, replacing the ad hoc dhit/ihit enables.

---
 rtl/hazard_if.sv | 51 +++++
 rtl/hazard_unit.sv | 193 +++++++++++++++++++
 tb/tb_hazard_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller bundle: datapath status and ID-stage decode in,
// PC / pipeline latch controls and forwarding selects out.
interface hazard_if #(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    localparam int SEL_W = $clog2(DEPTH);

    // Datapath status and ID-stage decode
    logic              ihit;
    logic              dhit;
    logic              mem_req;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wen;
    logic [REG_AW-1:0] id_dest;
    logic              id_load;
    logic              id_halt;
    logic              br_taken;

    // Pipeline controls
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic [DEPTH-1:0]  stage_en;
    logic [DEPTH-1:0]  stage_flush;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;

    // Datapath / control-unit side
    modport master (
        output ihit, dhit, mem_req, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wen, id_dest, id_load, id_halt, br_taken,
        input  pc_en, ifid_en, ifid_flush, stage_en, stage_flush,
               fwd_a_sel, fwd_b_sel, halted, stall_cnt
    );

    // Hazard unit side
    modport slave (
        input  ihit, dhit, mem_req, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wen, id_dest, id_load, id_halt, br_taken,
        output pc_en, ifid_en, ifid_flush, stage_en, stage_flush,
               fwd_a_sel, fwd_b_sel, halted, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: tracks in-flight instruction metadata in a
// shadow pipeline and derives stalls, flushes, forwarding and halt.
module hazard_unit #(
    parameter int DEPTH    = 3,
    parameter int REG_AW   = 5,
    parameter int FWD_EN   = 1,
    parameter int BR_STAGE = 1,
    parameter int CNT_W    = 32
) (
    input  logic    CLK,
    input  logic    nRST,
    hazard_if.slave hif
);
    localparam int SEL_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [REG_AW-1:0] dest;
        logic              load;
        logic              halt;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
    } entry_t;

    entry_t           shadow_reg  [DEPTH];
    entry_t           shadow_next [DEPTH];
    entry_t           id_entry;

    logic [DEPTH-1:0] writer;
    logic [DEPTH-1:0] id_rs_hit;
    logic [DEPTH-1:0] id_rt_hit;
    logic [DEPTH-1:0] ex_rs_hit;
    logic [DEPTH-1:0] ex_rt_hit;
    logic [DEPTH-1:0] halt_vec;
    logic [DEPTH-1:0] br_mask;

    logic             mem_wait;
    logic             raw;
    logic             halt_block;
    logic             advance;
    logic             stall;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic [DEPTH-1:0] stage_en;
    logic [DEPTH-1:0] stage_flush;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic             halted_reg;
    logic             halted_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    assign id_entry = '{valid:  hif.id_valid,
                        wen:    hif.id_wen,
                        dest:   hif.id_dest,
                        load:   hif.id_load,
                        halt:   hif.id_halt,
                        rs:     hif.id_rs,
                        rt:     hif.id_rt,
                        use_rs: hif.id_use_rs,
                        use_rt: hif.id_use_rt};

    // Per-entry decode: register writers, dependency hits and halt presence.
    // $0 is never a writer, so it can neither stall nor forward.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign writer[gi]    = shadow_reg[gi].valid & shadow_reg[gi].wen &
                                   (shadow_reg[gi].dest != '0);
            assign id_rs_hit[gi] = writer[gi] & hif.id_use_rs & (shadow_reg[gi].dest == hif.id_rs);
            assign id_rt_hit[gi] = writer[gi] & hif.id_use_rt & (shadow_reg[gi].dest == hif.id_rt);
            assign halt_vec[gi]  = shadow_reg[gi].valid & shadow_reg[gi].halt;
            assign br_mask[gi]   = (gi <= BR_STAGE);
            if (gi == 0) begin : g_ex
                // EX cannot forward to itself
                assign ex_rs_hit[gi] = 1'b0;
                assign ex_rt_hit[gi] = 1'b0;
            end else begin : g_older
                assign ex_rs_hit[gi] = writer[gi] & shadow_reg[0].use_rs &
                                       (shadow_reg[gi].dest == shadow_reg[0].rs);
                assign ex_rt_hit[gi] = writer[gi] & shadow_reg[0].use_rt &
                                       (shadow_reg[gi].dest == shadow_reg[0].rt);
            end
        end
    endgenerate

    // With forwarding only a load sitting in EX is unresolvable; without it
    // any pending writer blocks the reader until it retires.
    assign mem_wait   = hif.mem_req & ~hif.dhit;
    assign raw        = hif.id_valid & ((FWD_EN != 0) ?
                        ((id_rs_hit[0] | id_rt_hit[0]) & shadow_reg[0].load) :
                        (|(id_rs_hit | id_rt_hit)));
    assign halt_block = (hif.id_halt & hif.id_valid) | (|halt_vec);

    // Prioritised control resolution; first matching condition wins.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        stage_en    = '1;
        stage_flush = '0;
        advance     = 1'b1;
        stall       = 1'b0;
        if (halted_reg) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            stage_en = '0;
            advance  = 1'b0;
        end else if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            stage_en = '0;
            advance  = 1'b0;
            stall    = 1'b1;
        end else if (hif.br_taken) begin
            // The ID instruction is discarded here, so a coincident RAW is moot
            ifid_flush  = 1'b1;
            stage_flush = br_mask;
        end else if (raw) begin
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            stage_flush[0] = 1'b1;
            stall          = 1'b1;
        end else if (halt_block) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end else if (!hif.ihit) begin
            pc_en          = 1'b0;
            ifid_en        = 1'b0;
            stage_flush[0] = 1'b1;
            stall          = 1'b1;
        end
    end

    // Next shadow contents: shift one stage, flushed slots become bubbles.
    always_comb begin
        shadow_next[0] = stage_flush[0] ? '0 : id_entry;
        for (int k = 1; k < DEPTH; k++) begin
            shadow_next[k] = stage_flush[k] ? '0 : shadow_reg[k-1];
        end
    end

    // Forward select: walk oldest to youngest so the youngest writer wins.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        if (FWD_EN != 0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ex_rs_hit[k]) fwd_a_sel = SEL_W'(k);
                if (ex_rt_hit[k]) fwd_b_sel = SEL_W'(k);
            end
        end
    end

    // Halt latches as the halt instruction reaches the last stage.
    assign halted_next = halted_reg |
                         (advance & shadow_next[DEPTH-1].valid & shadow_next[DEPTH-1].halt);

    // Shadow pipeline and sticky halt flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < DEPTH; k++) shadow_reg[k] <= '0;
            halted_reg <= 1'b0;
        end else begin
            if (advance) begin
                for (int k = 0; k < DEPTH; k++) shadow_reg[k] <= shadow_next[k];
            end
            halted_reg <= halted_next;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign hif.pc_en       = pc_en;
    assign hif.ifid_en     = ifid_en;
    assign hif.ifid_flush  = ifid_flush;
    assign hif.stage_en    = stage_en;
    assign hif.stage_flush = stage_flush;
    assign hif.fwd_a_sel   = fwd_a_sel;
    assign hif.fwd_b_sel   = fwd_b_sel;
    assign hif.halted      = halted_reg;
    assign hif.stall_cnt   = stall_cnt_reg;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a forwarding instance (dut1) and a
// stall-until-retired instance with a 2-bit stall counter (dut0).
module tb_hazard_unit;
    // Control word layout: {pc_en, ifid_en, ifid_flush, stage_en[2:0], stage_flush[2:0]}
    localparam logic [8:0] C_NORMAL = 9'b1_1_0_111_000;
    localparam logic [8:0] C_STALL  = 9'b0_0_0_111_001;
    localparam logic [8:0] C_REDIR  = 9'b1_1_1_111_011;
    localparam logic [8:0] C_FROZEN = 9'b0_0_0_000_000;
    localparam logic [8:0] C_HALTB  = 9'b0_1_1_111_000;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    // Stimulus, routed to the DUT chosen by tgt (1 = dut1, 0 = dut0); the other idles
    logic       tgt;
    logic       s_ihit, s_dhit, s_mem_req, s_id_valid, s_use_rs, s_use_rt;
    logic       s_wen, s_load, s_halt, s_br;
    logic [4:0] s_rs, s_rt, s_dest;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_if #(.DEPTH(3), .REG_AW(5), .CNT_W(32)) hif1 ();
    hazard_if #(.DEPTH(3), .REG_AW(5), .CNT_W(2))  hif0 ();

    hazard_unit #(.DEPTH(3), .REG_AW(5), .FWD_EN(1), .BR_STAGE(1), .CNT_W(32)) dut1 (
        .CLK(CLK), .nRST(nRST), .hif(hif1));
    hazard_unit #(.DEPTH(3), .REG_AW(5), .FWD_EN(0), .BR_STAGE(1), .CNT_W(2)) dut0 (
        .CLK(CLK), .nRST(nRST), .hif(hif0));

    assign hif1.ihit      = tgt ? s_ihit     : 1'b1;
    assign hif1.dhit      = tgt ? s_dhit     : 1'b1;
    assign hif1.mem_req   = tgt ? s_mem_req  : 1'b0;
    assign hif1.id_valid  = tgt ? s_id_valid : 1'b0;
    assign hif1.br_taken  = tgt ? s_br       : 1'b0;
    assign hif1.id_halt   = tgt ? s_halt     : 1'b0;
    assign hif1.id_rs     = s_rs;
    assign hif1.id_rt     = s_rt;
    assign hif1.id_use_rs = s_use_rs;
    assign hif1.id_use_rt = s_use_rt;
    assign hif1.id_wen    = s_wen;
    assign hif1.id_dest   = s_dest;
    assign hif1.id_load   = s_load;

    assign hif0.ihit      = !tgt ? s_ihit     : 1'b1;
    assign hif0.dhit      = !tgt ? s_dhit     : 1'b1;
    assign hif0.mem_req   = !tgt ? s_mem_req  : 1'b0;
    assign hif0.id_valid  = !tgt ? s_id_valid : 1'b0;
    assign hif0.br_taken  = !tgt ? s_br       : 1'b0;
    assign hif0.id_halt   = !tgt ? s_halt     : 1'b0;
    assign hif0.id_rs     = s_rs;
    assign hif0.id_rt     = s_rt;
    assign hif0.id_use_rs = s_use_rs;
    assign hif0.id_use_rt = s_use_rt;
    assign hif0.id_wen    = s_wen;
    assign hif0.id_dest   = s_dest;
    assign hif0.id_load   = s_load;

    logic [8:0] ctl1, ctl0;
    assign ctl1 = {hif1.pc_en, hif1.ifid_en, hif1.ifid_flush, hif1.stage_en, hif1.stage_flush};
    assign ctl0 = {hif0.pc_en, hif0.ifid_en, hif0.ifid_flush, hif0.stage_en, hif0.stage_flush};

    task automatic clr();
        s_ihit = 1'b1; s_dhit = 1'b1; s_mem_req = 1'b0; s_br = 1'b0;
        s_id_valid = 1'b0; s_use_rs = 1'b0; s_use_rt = 1'b0; s_wen = 1'b0;
        s_load = 1'b0; s_halt = 1'b0; s_rs = '0; s_rt = '0; s_dest = '0;
    endtask

    task automatic id_nop();
        s_id_valid = 1'b0; s_use_rs = 1'b0; s_use_rt = 1'b0; s_wen = 1'b0;
        s_load = 1'b0; s_halt = 1'b0;
    endtask

    task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                            input logic urt, input logic wen, input logic [4:0] dest,
                            input logic load, input logic halt);
        s_id_valid = 1'b1; s_rs = rs; s_rt = rt; s_use_rs = urs; s_use_rt = urt;
        s_wen = wen; s_dest = dest; s_load = load; s_halt = halt;
    endtask

    // Opens the next cycle's window just after the active edge
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        clr(); tgt = 1'b1; nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        #1;
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL reset_ctl1: got %b want %b", ctl1, C_NORMAL); end
        n_cmp++; if ({hif1.fwd_a_sel, hif1.fwd_b_sel} !== 4'b0) begin n_bad++; $display("FAIL reset_sel: got %b want 0000", {hif1.fwd_a_sel, hif1.fwd_b_sel}); end
        n_cmp++; if (hif1.halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", hif1.halted); end
        n_cmp++; if (hif1.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt1: got %0d want 0", hif1.stall_cnt); end
        n_cmp++; if (ctl0 !== C_NORMAL) begin n_bad++; $display("FAIL reset_ctl0: got %b want %b", ctl0, C_NORMAL); end
        n_cmp++; if (hif0.stall_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt0: got %0d want 0", hif0.stall_cnt); end
        $display("test_reset: done");
    endtask

    task automatic test_load_use();
        next_cycle(); id_instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0); #1;  // lw $2
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL lu_issue: got %b want %b", ctl1, C_NORMAL); end
        next_cycle(); id_instr(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0); #1;  // addu $4,$2,$3
        n_cmp++; if (ctl1 !== C_STALL) begin n_bad++; $display("FAIL lu_stall: got %b want %b", ctl1, C_STALL); end
        next_cycle(); #1;
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL lu_release: got %b want %b", ctl1, C_NORMAL); end
        n_cmp++; if (hif1.stall_cnt !== 32'd1) begin n_bad++; $display("FAIL lu_cnt: got %0d want 1", hif1.stall_cnt); end
        next_cycle(); id_nop(); #1;
        n_cmp++; if (hif1.fwd_a_sel !== 2'd2) begin n_bad++; $display("FAIL lu_fwd_a: got %0d want 2", hif1.fwd_a_sel); end
        n_cmp++; if (hif1.fwd_b_sel !== 2'd0) begin n_bad++; $display("FAIL lu_fwd_b: got %0d want 0", hif1.fwd_b_sel); end
        $display("test_load_use: done");
    endtask

    task automatic test_fwd_priority();
        next_cycle(); id_instr(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);  // older writer of $5
        next_cycle(); id_instr(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);  // younger writer of $5
        next_cycle(); id_instr(5'd6, 5'd5, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);  // reads $6, $5
        next_cycle(); id_nop(); #1;
        n_cmp++; if (hif1.fwd_b_sel !== 2'd1) begin n_bad++; $display("FAIL fp_young_b: got %0d want 1", hif1.fwd_b_sel); end
        n_cmp++; if (hif1.fwd_a_sel !== 2'd0) begin n_bad++; $display("FAIL fp_none_a: got %0d want 0", hif1.fwd_a_sel); end
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL fp_ctl: got %b want %b", ctl1, C_NORMAL); end
        next_cycle(); id_instr(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);  // writes $0
        next_cycle(); id_instr(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);  // reads $0,$0
        next_cycle(); id_nop(); #1;
        n_cmp++; if ({hif1.fwd_a_sel, hif1.fwd_b_sel} !== 4'b0) begin n_bad++; $display("FAIL fp_r0_sel: got %b want 0000", {hif1.fwd_a_sel, hif1.fwd_b_sel}); end
        next_cycle(); id_instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);  // lw $0
        next_cycle(); id_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #1;  // reads $0
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL fp_r0_nostall: got %b want %b", ctl1, C_NORMAL); end
        $display("test_fwd_priority: done");
    endtask

    task automatic test_redirect();
        next_cycle(); id_instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0); s_br = 1'b1; #1;  // lw $7 squashed
        n_cmp++; if (ctl1 !== C_REDIR) begin n_bad++; $display("FAIL rd_flush: got %b want %b", ctl1, C_REDIR); end
        next_cycle(); s_br = 1'b0; id_instr(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL rd_bubble: got %b want %b", ctl1, C_NORMAL); end
        next_cycle(); id_instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0); #1;  // lw $8
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL rd_lw8: got %b want %b", ctl1, C_NORMAL); end
        next_cycle(); id_instr(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); s_br = 1'b1; #1;
        n_cmp++; if (ctl1 !== C_REDIR) begin n_bad++; $display("FAIL rd_over_raw: got %b want %b", ctl1, C_REDIR); end
        $display("test_redirect: done");
    endtask

    task automatic test_mem_wait();
        next_cycle(); id_nop(); s_br = 1'b1; s_mem_req = 1'b1; s_dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #1;
            n_cmp++; if (ctl1 !== C_FROZEN) begin n_bad++; $display("FAIL mw_frozen%0d: got %b want %b", i, ctl1, C_FROZEN); end
        end
        next_cycle(); s_dhit = 1'b1; #1;
        n_cmp++; if (ctl1 !== C_REDIR) begin n_bad++; $display("FAIL mw_deferred: got %b want %b", ctl1, C_REDIR); end
        n_cmp++; if (hif1.stall_cnt !== 32'd4) begin n_bad++; $display("FAIL mw_cnt: got %0d want 4", hif1.stall_cnt); end
        // Shadow must hold a pending load across a memory wait
        next_cycle(); s_br = 1'b0; s_mem_req = 1'b0; id_instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0); #1;
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL mw_lw9: got %b want %b", ctl1, C_NORMAL); end
        next_cycle(); s_mem_req = 1'b1; s_dhit = 1'b0; id_instr(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        next_cycle(); #1;
        n_cmp++; if (ctl1 !== C_FROZEN) begin n_bad++; $display("FAIL mw_over_raw: got %b want %b", ctl1, C_FROZEN); end
        next_cycle(); s_mem_req = 1'b0; s_dhit = 1'b1; #1;
        n_cmp++; if (ctl1 !== C_STALL) begin n_bad++; $display("FAIL mw_held_load: got %b want %b", ctl1, C_STALL); end
        n_cmp++; if (hif1.stall_cnt !== 32'd6) begin n_bad++; $display("FAIL mw_cnt2: got %0d want 6", hif1.stall_cnt); end
        next_cycle(); #1;
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL mw_resume: got %b want %b", ctl1, C_NORMAL); end
        $display("test_mem_wait: done");
    endtask

    task automatic test_fetch_wait();
        next_cycle(); id_nop(); s_ihit = 1'b0; #1;
        n_cmp++; if (ctl1 !== C_STALL) begin n_bad++; $display("FAIL fw_ctl: got %b want %b", ctl1, C_STALL); end
        next_cycle(); s_ihit = 1'b1; #1;
        n_cmp++; if (hif1.stall_cnt !== 32'd8) begin n_bad++; $display("FAIL fw_cnt: got %0d want 8", hif1.stall_cnt); end
        $display("test_fetch_wait: done");
    endtask

    task automatic test_no_fwd();
        next_cycle(); clr(); tgt = 1'b0; id_instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0); #1;  // addi $3
        n_cmp++; if (ctl0 !== C_NORMAL) begin n_bad++; $display("FAIL nf_issue: got %b want %b", ctl0, C_NORMAL); end
        next_cycle(); id_instr(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);  // or $6,$3,$4
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #1;
            n_cmp++; if (ctl0 !== C_STALL) begin n_bad++; $display("FAIL nf_stall%0d: got %b want %b", i, ctl0, C_STALL); end
        end
        next_cycle(); #1;
        n_cmp++; if (ctl0 !== C_NORMAL) begin n_bad++; $display("FAIL nf_release: got %b want %b", ctl0, C_NORMAL); end
        n_cmp++; if (hif0.stall_cnt !== 2'd3) begin n_bad++; $display("FAIL nf_cnt: got %0d want 3", hif0.stall_cnt); end
        next_cycle(); id_nop(); #1;
        n_cmp++; if ({hif0.fwd_a_sel, hif0.fwd_b_sel} !== 4'b0) begin n_bad++; $display("FAIL nf_sel: got %b want 0000", {hif0.fwd_a_sel, hif0.fwd_b_sel}); end
        next_cycle(); s_ihit = 1'b0;
        next_cycle(); s_ihit = 1'b1; #1;
        n_cmp++; if (hif0.stall_cnt !== 2'd3) begin n_bad++; $display("FAIL nf_saturate: got %0d want 3", hif0.stall_cnt); end
        $display("test_no_fwd: done");
    endtask

    task automatic test_halt();
        next_cycle(); clr(); tgt = 1'b1; id_instr(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); #1;
        n_cmp++; if (ctl1 !== C_HALTB) begin n_bad++; $display("FAIL ht_block0: got %b want %b", ctl1, C_HALTB); end
        next_cycle(); id_nop(); #1;
        n_cmp++; if (ctl1 !== C_HALTB) begin n_bad++; $display("FAIL ht_block1: got %b want %b", ctl1, C_HALTB); end
        next_cycle(); #1;
        n_cmp++; if (hif1.halted !== 1'b0) begin n_bad++; $display("FAIL ht_early: got %b want 0", hif1.halted); end
        next_cycle(); #1;
        n_cmp++; if (hif1.halted !== 1'b1) begin n_bad++; $display("FAIL ht_set: got %b want 1", hif1.halted); end
        n_cmp++; if (ctl1 !== C_FROZEN) begin n_bad++; $display("FAIL ht_frozen: got %b want %b", ctl1, C_FROZEN); end
        next_cycle(); #1;
        n_cmp++; if (hif1.halted !== 1'b1) begin n_bad++; $display("FAIL ht_sticky: got %b want 1", hif1.halted); end
        n_cmp++; if (hif1.stall_cnt !== 32'd8) begin n_bad++; $display("FAIL ht_cnt: got %0d want 8", hif1.stall_cnt); end
        #2 nRST = 1'b0;
        #1;
        n_cmp++; if (hif1.halted !== 1'b0) begin n_bad++; $display("FAIL ht_async_halt: got %b want 0", hif1.halted); end
        n_cmp++; if (hif1.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL ht_async_cnt: got %0d want 0", hif1.stall_cnt); end
        #2 nRST = 1'b1;
        next_cycle(); #1;
        n_cmp++; if (ctl1 !== C_NORMAL) begin n_bad++; $display("FAIL ht_after_rst: got %b want %b", ctl1, C_NORMAL); end
        $display("test_halt: done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_redirect();
        test_mem_wait();
        test_fetch_wait();
        test_no_fwd();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
